// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus launch sequencer placed directly in front of uart_tx.
//   Producers push bytes at any rate. The sequencer hands them to uart_tx one
//   at a time over the start_tx/busy handshake. If uart_tx never raises busy
//   after a launch, the byte is dropped and ack_err pulses.
//
// Ports
//   clk_25mhz  in   system clock
//   resetn     in   asynchronous active-low reset
//   wr_en      in   push wr_data this cycle
//   wr_data    in   byte to enqueue
//   full       out  FIFO holds DEPTH bytes (registered)
//   empty      out  FIFO holds no bytes (registered)
//   level      out  current byte count (registered)
//   overflow   out  sticky, set when a push is rejected
//   clr_ovf    in   clears overflow (a rejected push in the same cycle wins)
//   tx_data    out  byte presented to uart_tx, held until the next launch
//   tx_start   out  one-cycle launch pulse to uart_tx start_tx
//   tx_busy    in   uart_tx busy
//   ack_err    out  one-cycle pulse, launch was never acknowledged
module uart_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                     clk_25mhz,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     ack_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   ack_cnt_r;
    logic [LW-1:0]   level_nxt_s;
    logic            push_s;
    logic            pop_s;

    // A full FIFO rejects the push even when a pop happens in the same cycle,
    // so acceptance depends only on the registered full flag.
    assign push_s = wr_en & ~full;
    // Launch only from IDLE with data queued and the transmitter idle.
    assign pop_s  = (state_r == ST_IDLE) & ~empty & ~tx_busy;

    // Next byte count from this cycle's accepted push and pop.
    always_comb begin
        level_nxt_s = level;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level + LVL_ONE;
            2'b01:   level_nxt_s = level - LVL_ONE;
            default: level_nxt_s = level;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_25mhz) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, count, status flags and sticky overflow.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level    <= LVL_ZERO;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level <= level_nxt_s;
            full  <= (level_nxt_s == LVL_FULL);
            empty <= (level_nxt_s == LVL_ZERO);
            // A rejected push takes priority over a clear in the same cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Launch sequencer: IDLE -> WAIT_ACK -> WAIT_DONE, all outputs registered.
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            ack_err   <= 1'b0;
            ack_cnt_r <= '0;
        end else begin
            tx_start <= 1'b0;
            ack_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data   <= mem_r[rd_ptr_r];
                        tx_start  <= 1'b1;
                        ack_cnt_r <= '0;
                        state_r   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // Counter value N means N+1 cycles have elapsed in this state
                    // by the end of the current cycle.
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (ack_cnt_r == CNT_LAST) begin
                        ack_err <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    logic       clk_25mhz = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       ack_err;

    // uart_tx stand-in: busy for 10 cycles after sampling start_tx
    logic       model_en;
    logic       busy_force;
    logic [3:0] busy_cnt;
    logic       model_busy;

    int errors = 0;
    int checks = 0;
    int launches = 0;
    int ack_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ack_cyc = 0;
    int peak = 0;
    int n_saved = 0;
    logic prev_start = 1'b0;
    logic [7:0] exp_q [$];

    always #20 clk_25mhz = ~clk_25mhz;

    uart_tx_feeder dut (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .ack_err   (ack_err)
    );

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            busy_cnt <= 4'd0;
        end else if (tx_start && model_en) begin
            busy_cnt <= 4'd10;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end

    assign model_busy = (busy_cnt != 4'd0);
    assign tx_busy    = busy_force | model_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
        if (level > peak) peak = level;
    endtask

    task automatic wait_idle;
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got tx_busy=1 after 60 cycles, required 0");
        end
        repeat (2) tick();
    endtask

    task automatic wait_launches(input int target, input int bound);
        for (int i = 0; i < bound && launches < target; i++) begin
            tick();
            if (level > peak) peak = level;
        end
        chk("launch_count", 32'(launches), 32'(target));
    endtask

    // Scoreboard monitor: every launch pops the expected byte.
    task automatic mon_loop;
        forever begin
            @(negedge clk_25mhz);
            cyc++;
            if (resetn) begin
                if (tx_start) begin
                    launches++;
                    start_cyc = cyc;
                    chk("start_single_cycle", 32'(prev_start), 32'd0);
                    chk("one_outstanding", 32'(model_busy), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_launch: got tx_data=%0h, required no launch", tx_data);
                    end else begin
                        chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                end
                if (ack_err) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                end
            end
            prev_start = tx_start;
        end
    endtask

    initial begin
        resetn     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        clr_ovf    = 1'b0;
        busy_force = 1'b0;
        model_en   = 1'b1;
        fork
            mon_loop();
        join_none

        // reset state
        repeat (3) tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        resetn = 1'b1;
        tick();

        // 1: single byte, launch two edges after the push
        push(8'h55, 1'b1);
        chk("t1_level_after_push", 32'(level), 32'd1);
        chk("t1_empty_after_push", 32'(empty), 32'd0);
        chk("t1_start_early", 32'(tx_start), 32'd0);
        tick();
        chk("t1_tx_start", 32'(tx_start), 32'd1);
        chk("t1_tx_data", 32'(tx_data), 32'h55);
        chk("t1_empty_after_pop", 32'(empty), 32'd1);
        chk("t1_level_after_pop", 32'(level), 32'd0);
        tick();
        chk("t1_start_dropped", 32'(tx_start), 32'd0);
        wait_idle();
        chk("t1_launches", 32'(launches), 32'd1);
        chk("t1_data_held", 32'(tx_data), 32'h55);

        // 2: back-to-back burst
        peak = 0;
        push(8'h41, 1'b1);
        push(8'h42, 1'b1);
        push(8'h43, 1'b1);
        push(8'h44, 1'b1);
        wait_launches(5, 200);
        chk("t2_peak_level", 32'((peak >= 3) && (peak <= 4)), 32'd1);
        wait_idle();
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: fill to DEPTH with the transmitter held busy, then overflow
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'h60 + 8'(i), 1'b1);
        end
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level16", 32'(level), 32'd16);
        chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
        chk("t3_no_launch", 32'(launches), 32'd5);
        push(8'h7F, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_level_kept", 32'(level), 32'd16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);

        // 5: push into full FIFO on the same edge as a pop
        busy_force = 1'b0;
        wr_en      = 1'b1;
        wr_data    = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("t5_overflow", 32'(overflow), 32'd1);
        chk("t5_level15", 32'(level), 32'd15);
        chk("t5_full", 32'(full), 32'd0);
        chk("t5_tx_start", 32'(tx_start), 32'd1);

        // 6: reset while in WAIT_DONE with 5 bytes queued
        begin
            bit found = 1'b0;
            for (int i = 0; i < 400; i++) begin
                tick();
                if (level == 5'd5 && tx_busy) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL t6_reach_level5: got level=%0d, required 5 with busy", level);
            end
        end
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        chk("t6_tx_start", 32'(tx_start), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        n_saved = launches;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (20) tick();
        chk("t6_no_launch", 32'(launches), 32'(n_saved));
        chk("t6_still_empty", 32'(empty), 32'd1);

        // 4: transmitter never acknowledges
        model_en = 1'b0;
        push(8'hA5, 1'b1);
        for (int i = 0; i < 40 && ack_cnt < 1; i++) tick();
        chk("t4_ack_seen", 32'(ack_cnt), 32'd1);
        chk("t4_ack_delay", 32'(ack_cyc - start_cyc), 32'd8);
        repeat (5) tick();
        chk("t4_ack_single", 32'(ack_cnt), 32'd1);
        chk("t4_empty", 32'(empty), 32'd1);
        model_en = 1'b1;
        push(8'hB6, 1'b1);
        wait_launches(n_saved + 2, 40);
        repeat (2) tick();
        chk("t4_next_busy", 32'(tx_busy), 32'd1);
        wait_idle();
        chk("t4_no_more_ack", 32'(ack_cnt), 32'd1);
        chk("t4_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
